// File: rtl/arbitro_somador.sv
// arbitro_somador: round-robin arbiter that shares one TAM-bit adder among NREQ requesters.
// Operands are latched at grant, and the registered {carry,sum} returns with a one-cycle ack.
module arbitro_somador #(
  parameter int TAM  = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*TAM-1:0] a_in,
  input  logic [NREQ*TAM-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [TAM:0]      resultado,
  output logic              ocupado
);
  typedef enum logic [1:0] {IDLE, CALC, ACK} state_t;
  state_t r_state;
  logic [1:0] r_ptr, r_win, w_win, w_idx;
  logic [TAM-1:0] r_a, r_b;
  // Scan from the farthest ring position back to ptr so the nearest set bit wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      w_win = req[w_idx] ? w_idx : w_win;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      gnt       <= '0;
      ack       <= '0;
      resultado <= '0;
      ocupado   <= 1'b0;
    end else if (r_state == IDLE && |req) begin
      r_win   <= w_win;
      r_a     <= a_in[w_win*TAM +: TAM];
      r_b     <= b_in[w_win*TAM +: TAM];
      gnt     <= NREQ'(1) << w_win;
      ocupado <= 1'b1;
      r_state <= CALC;
    end else if (r_state == CALC) begin
      resultado <= {1'b0, r_a} + {1'b0, r_b};
      ack       <= gnt;
      r_state   <= ACK;
    end else if (r_state == ACK) begin
      ack     <= '0;
      gnt     <= '0;
      ocupado <= 1'b0;
      r_ptr   <= r_win + 2'd1;
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_arbitro_somador.sv
// tb_arbitro_somador: directed stimulus with a scoreboard queue; a negedge monitor
// pops the expected winner/result whenever ack is presented.
module tb_arbitro_somador;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt, ack;
  logic [8:0]  resultado;
  logic        ocupado;
  logic [3:0]  l_ack;
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int last_ack = 0;
  typedef struct {
    int         who;
    logic [8:0] res;
    int         gap;
  } exp_t;
  exp_t sb[$];

  arbitro_somador #(.TAM(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .ack(ack), .resultado(resultado), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    if (rst === 1'b0 && ack !== 4'b0000) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: ack=%b resultado=%h, none expected", ack, resultado);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ack !== 4'(1 << e.who) || resultado !== e.res || gnt !== ack) begin
          bad++;
          $display("FAIL ack_req%0d: ack=%b gnt=%b resultado=%h, required ack=gnt=%b resultado=%h",
                   e.who, ack, gnt, resultado, 4'(1 << e.who), e.res);
        end
        if (e.gap != 0 && ncyc - last_ack != e.gap) begin
          bad++;
          $display("FAIL ack_spacing_req%0d: gap=%0d, required %0d", e.who, ncyc - last_ack, e.gap);
        end
      end
      last_ack = ncyc;
    end
  end

  task automatic cyc();
    @(negedge clk);
    l_ack = (rst === 1'b1) ? 4'b0000 : ack;
    @(posedge clk);
    #1;
    req = req & ~l_ack;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*8 +: 8] = a;
    b_in[i*8 +: 8] = b;
  endtask

  task automatic expect_ack(input int w, input logic [8:0] r, input int gap);
    exp_t e;
    e.who = w;
    e.res = r;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] g, input logic [3:0] a,
                     input logic [8:0] r, input logic o);
    total++;
    if (gnt !== g || ack !== a || resultado !== r || ocupado !== o) begin
      bad++;
      $display("FAIL %s: gnt=%b ack=%b resultado=%h ocupado=%b, required %b %b %h %b",
               name, gnt, ack, resultado, ocupado, g, a, r, o);
    end
  endtask

  task automatic serve(input int i, input logic [7:0] a, input logic [7:0] b, input logic [8:0] r);
    set_op(i, a, b);
    req[i] = 1'b1;
    expect_ack(i, r, 0);
    repeat (3) cyc();
    chk($sformatf("held_after_req%0d", i), 4'b0000, 4'b0000, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i), 8'(10 * i));
    cyc();
    cyc();
    chk("reset", 4'b0000, 4'b0000, 9'h000, 1'b0);
    rst = 1'b0;
    // fairness with every requester pending; req0 re-asserted with new operands
    expect_ack(0, 9'd0, 0);
    expect_ack(1, 9'd11, 3);
    expect_ack(2, 9'd22, 3);
    expect_ack(3, 9'd33, 3);
    cyc();
    chk("first_grant_req0", 4'b0001, 4'b0000, 9'h000, 1'b1);
    repeat (5) cyc();
    set_op(0, 8'd5, 8'd7);
    req[0] = 1'b1;
    expect_ack(0, 9'd12, 3);
    repeat (9) cyc();
    repeat (2) cyc();
    total++;
    if (req !== 4'b0000) begin
      bad++;
      $display("FAIL fairness_drain: req=%b, required 0000", req);
    end
    // wrap: serve 3, then 0 wins over 2; winner operands change during CALC
    expect_ack(3, 9'd33, 0);
    req = 4'b1000;
    repeat (3) cyc();
    set_op(0, 8'h80, 8'h80);
    set_op(2, 8'h40, 8'h02);
    req = 4'b0101;
    expect_ack(0, 9'h100, 0);
    expect_ack(2, 9'h042, 3);
    cyc();
    chk("wrap_grant_req0", 4'b0001, 4'b0000, 9'd33, 1'b1);
    set_op(0, 8'h00, 8'h00);
    repeat (5) cyc();
    chk("wrap_done", 4'b0000, 4'b0000, 9'h042, 1'b0);
    // single request on requester 1
    set_op(1, 8'h12, 8'h34);
    req = 4'b0010;
    expect_ack(1, 9'h046, 0);
    cyc();
    chk("single_calc", 4'b0010, 4'b0000, 9'h042, 1'b1);
    cyc();
    chk("single_ack", 4'b0010, 4'b0010, 9'h046, 1'b1);
    cyc();
    chk("single_idle", 4'b0000, 4'b0000, 9'h046, 1'b0);
    // carry out
    serve(2, 8'hFF, 8'h01, 9'h100);
    serve(2, 8'hFF, 8'hFF, 9'h1FE);
    // reset during CALC aborts; ptr returns to 0 so requester 2 beats 3
    set_op(2, 8'h10, 8'h20);
    req = 4'b0100;
    cyc();
    chk("calc_before_reset", 4'b0100, 4'b0000, 9'h1FE, 1'b1);
    rst = 1'b1;
    cyc();
    chk("reset_in_calc", 4'b0000, 4'b0000, 9'h000, 1'b0);
    rst = 1'b0;
    req = 4'b1100;
    expect_ack(2, 9'h030, 0);
    expect_ack(3, 9'd33, 3);
    repeat (6) cyc();
    repeat (2) cyc();
    total++;
    if (sb.size() != 0 || req !== 4'b0000) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d acks missing, req=%b", sb.size(), req);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
